// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
// Holds the stage-register state encoding, the stall counter width and the
// packed payload layouts that each stage passes through pipe_skid_reg
// (instantiate with WIDTH = $bits(<payload>_t)).
// Optional feature macro used by pipe_skid_reg: PIPE_STALL_CNT_EN.
package pipe_pkg;

   // Occupancy of a stage register: nothing held, main only, main and skid.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } pipe_state_e;

   localparam int unsigned STALL_CNT_W = 32;

   // IF -> ID: fetched instruction and its address.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_payload_t;

   // ID -> EX: decoded fields plus register operands (153 bits).
   typedef struct packed {
      logic [4:0]  rd_addr;
      logic [6:0]  funct7;
      logic [2:0]  funct3;
      logic [31:0] imm;
      logic [31:0] rs2_data;
      logic [31:0] rs1_data;
      logic [31:0] pc;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
   } id_ex_payload_t;

   // EX -> MEM: ALU result and store data.
   typedef struct packed {
      logic [4:0]  rd_addr;
      logic [31:0] alu_result;
      logic [31:0] rs2_data;
      logic [31:0] pc;
   } ex_mem_payload_t;

   // MEM -> WB: write-back value and destination.
   typedef struct packed {
      logic [4:0]  rd_addr;
      logic [31:0] wb_data;
   } mem_wb_payload_t;

   localparam int unsigned IF_ID_PAYLOAD_W  = $bits(if_id_payload_t);
   localparam int unsigned ID_EX_PAYLOAD_W  = $bits(id_ex_payload_t);
   localparam int unsigned EX_MEM_PAYLOAD_W = $bits(ex_mem_payload_t);
   localparam int unsigned MEM_WB_PAYLOAD_W = $bits(mem_wb_payload_t);

endpackage

// File: rtl/pipe_sat_counter.sv
// Generic saturating up-counter with enable.
// Counts one per enabled cycle and sticks at all-ones; cleared only by reset.
module pipe_sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_r;
   logic         at_max_s;

   assign at_max_s = (cnt_r == {W{1'b1}});

   // Count enabled cycles, holding at the maximum value once reached.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r <= '0;
      end else if (en && !at_max_s) begin
         cnt_r <= cnt_r + W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/pipe_skid_reg.sv
// Parametrised pipeline stage register with valid/ready handshake and a
// 2-entry skid buffer (main + skid). in_ready comes straight from a flop, so
// the upstream ready path is cut while full throughput is kept under
// backpressure. Flush empties the stage synchronously.
// Optional feature: define PIPE_STALL_CNT_EN to add the stall_cnt port, a
// saturating count of cycles where a valid payload waits on the consumer.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH        = 32,
   parameter bit               CLR_ON_FLUSH = 1'b1,
   parameter logic [WIDTH-1:0] FLUSH_VAL    = '0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data
`ifdef PIPE_STALL_CNT_EN
   ,output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

   pipe_state_e      state_r;
   pipe_state_e      state_nxt_s;
   logic [WIDTH-1:0] main_r;
   logic [WIDTH-1:0] main_nxt_s;
   logic [WIDTH-1:0] skid_r;
   logic [WIDTH-1:0] skid_nxt_s;
   logic             in_ready_r;
   logic             acc_s;
   logic             snd_s;

   assign out_valid = (state_r != EMPTY);
   assign out_data  = main_r;
   assign in_ready  = in_ready_r;

   assign acc_s = in_valid & in_ready_r;
   assign snd_s = out_valid & out_ready;

   // Next-state and next-payload selection; flush overrides any transfer.
   always_comb begin
      state_nxt_s = state_r;
      main_nxt_s  = main_r;
      skid_nxt_s  = skid_r;
      if (flush) begin
         state_nxt_s = EMPTY;
         if (CLR_ON_FLUSH) begin
            main_nxt_s = FLUSH_VAL;
            skid_nxt_s = FLUSH_VAL;
         end else begin
            main_nxt_s = main_r;
            skid_nxt_s = skid_r;
         end
      end else begin
         case (state_r)
            EMPTY: begin
               if (acc_s) begin
                  main_nxt_s  = in_data;
                  state_nxt_s = BUSY;
               end else begin
                  state_nxt_s = EMPTY;
               end
            end
            BUSY: begin
               if (acc_s && snd_s) begin
                  main_nxt_s  = in_data;
                  state_nxt_s = BUSY;
               end else if (acc_s) begin
                  // Consumer stalled: park the new word in the skid slot.
                  skid_nxt_s  = in_data;
                  state_nxt_s = FULL;
               end else if (snd_s) begin
                  state_nxt_s = EMPTY;
               end else begin
                  state_nxt_s = BUSY;
               end
            end
            FULL: begin
               // in_ready is low here, so only the drain side can move.
               if (snd_s) begin
                  main_nxt_s  = skid_r;
                  state_nxt_s = BUSY;
               end else begin
                  state_nxt_s = FULL;
               end
            end
            default: begin
               state_nxt_s = EMPTY;
            end
         endcase
      end
   end

   // State, payload and registered in_ready update.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= EMPTY;
         main_r     <= FLUSH_VAL;
         skid_r     <= FLUSH_VAL;
         in_ready_r <= 1'b1;
      end else begin
         state_r    <= state_nxt_s;
         main_r     <= main_nxt_s;
         skid_r     <= skid_nxt_s;
         in_ready_r <= (state_nxt_s != FULL);
      end
   end

`ifdef PIPE_STALL_CNT_EN
   logic stall_s;

   assign stall_s = out_valid & ~out_ready;

   pipe_sat_counter #(
      .W (STALL_CNT_W)
   ) u_stall_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (stall_s),
      .cnt     (stall_cnt)
   );
`endif

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised pipeline stage register. It is the successor to the fixed-field stage registers between IF/ID/EX/MEM/WB.
- Carries one packed payload of WIDTH bits.
- Uses a valid/ready handshake instead of the bare valid/flush enable.
- Includes a 2-entry skid buffer, so in_ready is a pure register output and the stage sustains full throughput under backpressure.
- Flush clears the stage.

Parameters:
WIDTH, 32, payload width in bits (1..256)
CLR_ON_FLUSH, 1, 1 = payload registers forced to FLUSH_VAL on flush; 0 = only valid state cleared, data left unchanged
FLUSH_VAL, 0, payload value loaded on reset (always) and on flush (when CLR_ON_FLUSH=1)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush; drops all held and incoming data
in_valid  in  1  upstream holds a valid payload
in_ready  out  1  stage can accept; registered
in_data  in  WIDTH  upstream payload
out_valid  out  1  stage holds a valid payload
out_ready  in  1  downstream accepts
out_data  out  WIDTH  payload; always driven from the main register
stall_cnt  out  32  saturating stall count; present only with PIPE_STALL_CNT_EN

Behaviour:
- Storage: main register (main_q), skid register (skid_q), state register.
- States: EMPTY (nothing held), BUSY (main valid, skid empty), FULL (both valid).
- Combinational outputs:
  - out_valid = (state != EMPTY).
  - out_data = main_q.
- Registered output: in_ready = next state != FULL.
- Accept condition: acc = in_valid & in_ready. Send condition: snd = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY, acc: main_q <= in_data; go to BUSY.
  - BUSY, acc & snd: main_q <= in_data; stay in BUSY.
  - BUSY, acc & !snd: skid_q <= in_data; go to FULL; in_ready drops next cycle.
  - BUSY, !acc & snd: go to EMPTY.
  - FULL, snd: main_q <= skid_q; go to BUSY. in_ready is 0 in FULL, so no accept can occur there.
  - All other cases: hold. main_q stays stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - Latency is 1 cycle: data accepted at edge N appears on out_data after edge N.
  - Throughput is 1 transfer/cycle when out_ready=1.
  - Ordering is strictly FIFO.
- Flush (synchronous, overrides every transfer in that cycle):
  - state <= EMPTY; in_ready <= 1.
  - Any input accepted in the flush cycle is discarded.
  - When CLR_ON_FLUSH=1: main_q <= FLUSH_VAL and skid_q <= FLUSH_VAL.
  - A downstream snd in the flush cycle still counts as taken by the consumer (out_valid was high).
- Reset (reset_n=0, asynchronous):
  - state=EMPTY, out_valid=0, in_ready=1.
  - main_q=skid_q=FLUSH_VAL, so out_data=FLUSH_VAL.
  - stall_cnt=0.
  - Reset mid-transfer drops all held data.
- X-safety: in_data is ignored when in_valid=0; out_data content is don't-care to consumers when out_valid=0.

Optional Feature:
PIPE_STALL_CNT_EN:
- When defined: stall_cnt port exists.
  - Increments by 1 each cycle out_valid=1 and out_ready=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset only, not by flush.
- When undefined: the port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2);
  - STALL_CNT_W=32 constant;
  - packed payload typedefs for each stage (e.g. id_ex_payload_t: rd_addr 5, funct7 7, funct3 3, imm 32, rs2_data 32, rs1_data 32, pc 32, rs1_addr 5, rs2_addr 5 = 153 bits), so stages instantiate pipe_skid_reg with WIDTH=$bits(payload).
- One sub-module: pipe_sat_counter (generic width saturating counter with enable), used for stall_cnt.

Test Plan:
- Reset with in_valid=1, in_data=0xDEADBEEF -> out_valid=0, out_data=0, in_ready=1 while reset_n=0; after release, first accept gives out_data=0xDEADBEEF one cycle later.
- Stream 0x1..0x8 with out_ready=1 every cycle -> out_data 0x1..0x8 on consecutive cycles, in_ready never drops, no gaps.
- Accept 0xA then 0xB with out_ready=0 -> state FULL, in_ready=0 next cycle, out_data holds 0xA; release out_ready -> 0xA then 0xB delivered in order, in_ready back to 1 after the first send.
- Flush in FULL with in_valid=1, in_data=0xC -> next cycle out_valid=0, out_data=0, in_ready=1; 0xA, 0xB and 0xC never appear. Repeat with CLR_ON_FLUSH=0 -> out_valid=0, out_data still 0xA.
- Async reset asserted mid-cycle in BUSY -> out_valid falls immediately, without waiting for a clock edge.
- With PIPE_STALL_CNT_EN: hold out_valid=1 and out_ready=0 for 5 cycles -> stall_cnt=5; flush -> stall_cnt stays 5; force counter to 0xFFFF_FFFE and stall 3 more cycles -> stall_cnt=0xFFFF_FFFF.
